// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD counter / 7-segment display block.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package bcd_disp_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [DIGIT_W-1:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Any nibble above 9 is clamped to 9 so the counter never leaves BCD range.
  function automatic logic [DIGIT_W-1:0] bcd_sat(input logic [DIGIT_W-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// Combinational up/down step logic for one BCD digit; registers live in the top.
// Out-of-range digits are clamped to 9 before stepping.
module bcd_digit_cell
  import bcd_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               up_dn,
  input  logic               step_in,
  output logic [DIGIT_W-1:0] next_digit,
  output logic               step_out,
  output logic               is_zero,
  output logic               is_nine
);

  logic [DIGIT_W-1:0] sat;

  assign sat     = bcd_sat(digit);
  assign is_zero = (sat == 4'd0);
  assign is_nine = (sat == 4'd9);

  always_comb begin
    next_digit = sat;
    step_out   = 1'b0;
    if (step_in) begin
      if (up_dn) begin
        if (is_nine) begin
          next_digit = 4'd0;
          step_out   = 1'b1;
        end else begin
          next_digit = sat + 4'd1;
        end
      end else begin
        if (is_zero) begin
          next_digit = 4'd9;
          step_out   = 1'b1;
        end else begin
          next_digit = sat - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with registered, time-multiplexed 7-segment drive.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module bcd_counter_display
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 2500000,
  parameter int REFRESH_BITS = 11
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          up_dn,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count_bcd,
  output logic                          wrap,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an
);

  localparam int CNT_W = DIGIT_W * NUM_DIGITS;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        div_q;
  logic                    tick_q;
  logic [REFRESH_BITS-1:0] scan_q;
  logic [IDX_W-1:0]        idx_q;

  logic [CNT_W-1:0]        count_next;
  logic [CNT_W-1:0]        load_sat;
  logic [NUM_DIGITS:0]     step;
  logic [NUM_DIGITS-1:0]   is_zero;
  logic [NUM_DIGITS-1:0]   is_nine;
  logic [NUM_DIGITS-1:0]   blank;
  logic [DIGIT_W-1:0]      sel_digit;
  logic                    sel_blank;
  logic                    unused_flags;

  // Tick divider: tick is high the cycle after the divider hits its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else if (en) begin
      div_q  <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      tick_q <= (div_q == DIV_LAST);
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign step[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .digit      (count_bcd[i*DIGIT_W +: DIGIT_W]),
      .up_dn      (up_dn),
      .step_in    (step[i]),
      .next_digit (count_next[i*DIGIT_W +: DIGIT_W]),
      .step_out   (step[i+1]),
      .is_zero    (is_zero[i]),
      .is_nine    (is_nine[i])
    );
  end

  always_comb begin
    load_sat = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      load_sat[k*DIGIT_W +: DIGIT_W] = bcd_sat(load_val[k*DIGIT_W +: DIGIT_W]);
    end
  end

  // Load wins over a coincident tick; carry out of the top digit is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_bcd <= '0;
      wrap      <= 1'b0;
    end else if (load) begin
      count_bcd <= load_sat;
      wrap      <= 1'b0;
    end else if (tick_q) begin
      count_bcd <= count_next;
      wrap      <= step[NUM_DIGITS];
    end else begin
      wrap      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else begin
      scan_q <= scan_q + REFRESH_BITS'(1);
      if (&scan_q) begin
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lead     = lead & is_zero[k];
      blank[k] = lead;
    end
  end
`else
  assign blank = '0;
`endif

  assign unused_flags = ^{is_nine, is_zero};

  always_comb begin
    sel_digit = '0;
    sel_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_digit = count_bcd[k*DIGIT_W +: DIGIT_W];
        sel_blank = blank[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= sel_blank ? SEG_BLANK : bcd_to_seg(sel_digit);
      an  <= ~(NUM_DIGITS'(1) << idx_q);
    end
  end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed testbench for bcd_counter_display (2 digits, tick every 4 clocks, 4-clock dwell).
// Expected values are hand-computed; honours LEADING_ZERO_BLANK_EN if defined.
module tb_bcd_counter_display;

  localparam logic [6:0] S_0     = 7'b1000000;
  localparam logic [6:0] S_1     = 7'b1111001;
  localparam logic [6:0] S_5     = 7'b0010010;
  localparam logic [6:0] S_7     = 7'b1111000;
  localparam logic [6:0] S_BLANK = 7'b1111111;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count_bcd;
  logic       wrap;
  logic [6:0] seg;
  logic [1:0] an;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_counter_display #(
    .NUM_DIGITS   (2),
    .TICK_DIV     (4),
    .REFRESH_BITS (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .count_bcd (count_bcd),
    .wrap      (wrap),
    .seg       (seg),
    .an        (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = 8'h00;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
    step(2);
    n_checks++; if (count_bcd !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_count got %h expected 00", count_bcd); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wrap got %b expected 0", wrap); end
    n_checks++; if (seg !== S_BLANK) begin n_fail++; $display("[TB] FAIL reset_seg got %b expected %b", seg, S_BLANK); end
    n_checks++; if (an !== 2'b11) begin n_fail++; $display("[TB] FAIL reset_an got %b expected 11", an); end
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    do_reset();
    en = 1'b1;
    step(4);
    n_checks++; if (count_bcd !== 8'h00) begin n_fail++; $display("[TB] FAIL up_before_tick got %h expected 00", count_bcd); end
    step(1);
    n_checks++; if (count_bcd !== 8'h01) begin n_fail++; $display("[TB] FAIL up_first_tick got %h expected 01", count_bcd); end
    step(35);
    n_checks++; if (count_bcd !== 8'h09) begin n_fail++; $display("[TB] FAIL up_ninth_tick got %h expected 09", count_bcd); end
    step(1);
    n_checks++; if (count_bcd !== 8'h10) begin n_fail++; $display("[TB] FAIL up_tenth_tick got %h expected 10", count_bcd); end
    en = 1'b0;
    step(2);
    n_checks++; if (an !== 2'b10) begin n_fail++; $display("[TB] FAIL up_an_d0 got %b expected 10", an); end
    n_checks++; if (seg !== S_0) begin n_fail++; $display("[TB] FAIL up_seg_d0 got %b expected %b", seg, S_0); end
    step(4);
    n_checks++; if (an !== 2'b01) begin n_fail++; $display("[TB] FAIL up_an_d1 got %b expected 01", an); end
    n_checks++; if (seg !== S_1) begin n_fail++; $display("[TB] FAIL up_seg_d1 got %b expected %b", seg, S_1); end
  endtask

  task automatic test_wrap();
    do_reset();
    load = 1'b1; load_val = 8'h98;
    step(1);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step(4);
    n_checks++; if (count_bcd !== 8'h98) begin n_fail++; $display("[TB] FAIL wrap_loaded got %h expected 98", count_bcd); end
    step(1);
    n_checks++; if (count_bcd !== 8'h99) begin n_fail++; $display("[TB] FAIL wrap_to_99 got %h expected 99", count_bcd); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_early got %b expected 0", wrap); end
    step(4);
    n_checks++; if (count_bcd !== 8'h00) begin n_fail++; $display("[TB] FAIL wrap_up_count got %h expected 00", count_bcd); end
    n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_up_pulse got %b expected 1", wrap); end
    step(1);
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_up_single got %b expected 0", wrap); end
    up_dn = 1'b0;
    step(3);
    n_checks++; if (count_bcd !== 8'h99) begin n_fail++; $display("[TB] FAIL wrap_dn_count got %h expected 99", count_bcd); end
    n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_dn_pulse got %b expected 1", wrap); end
    step(1);
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_dn_single got %b expected 0", wrap); end
  endtask

  task automatic test_load_priority();
    do_reset();
    up_dn = 1'b0; en = 1'b1;
    step(4);
    n_checks++; if (count_bcd !== 8'h00) begin n_fail++; $display("[TB] FAIL prio_pre got %h expected 00", count_bcd); end
    load = 1'b1; load_val = 8'h3C;
    step(1);
    n_checks++; if (count_bcd !== 8'h39) begin n_fail++; $display("[TB] FAIL prio_load got %h expected 39", count_bcd); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("[TB] FAIL prio_wrap got %b expected 0", wrap); end
    load = 1'b0; up_dn = 1'b1;
    step(1);
    n_checks++; if (count_bcd !== 8'h39) begin n_fail++; $display("[TB] FAIL prio_consumed got %h expected 39", count_bcd); end
    step(3);
    n_checks++; if (count_bcd !== 8'h40) begin n_fail++; $display("[TB] FAIL prio_carry got %h expected 40", count_bcd); end
  endtask

  task automatic test_load_saturate();
    do_reset();
    load = 1'b1; load_val = 8'hBA;
    step(1);
    load = 1'b0;
    n_checks++; if (count_bcd !== 8'h99) begin n_fail++; $display("[TB] FAIL sat_both got %h expected 99", count_bcd); end
    load = 1'b1; load_val = 8'h2F;
    step(1);
    load = 1'b0;
    n_checks++; if (count_bcd !== 8'h29) begin n_fail++; $display("[TB] FAIL sat_low got %h expected 29", count_bcd); end
  endtask

  task automatic test_down_borrow();
    do_reset();
    load = 1'b1; load_val = 8'h10;
    step(1);
    load = 1'b0; up_dn = 1'b0; en = 1'b1;
    step(5);
    n_checks++; if (count_bcd !== 8'h09) begin n_fail++; $display("[TB] FAIL borrow_count got %h expected 09", count_bcd); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("[TB] FAIL borrow_wrap got %b expected 0", wrap); end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    en = 1'b1;
    step(2);
    en = 1'b0;
    step(10);
    n_checks++; if (count_bcd !== 8'h00) begin n_fail++; $display("[TB] FAIL freeze_hold got %h expected 00", count_bcd); end
    en = 1'b1;
    step(2);
    n_checks++; if (count_bcd !== 8'h00) begin n_fail++; $display("[TB] FAIL freeze_resume_early got %h expected 00", count_bcd); end
    step(1);
    n_checks++; if (count_bcd !== 8'h01) begin n_fail++; $display("[TB] FAIL freeze_resume_tick got %h expected 01", count_bcd); end
  endtask

  task automatic test_scan();
    logic [6:0] exp_d1;
    do_reset();
    load = 1'b1; load_val = 8'h57;
    step(1);
    load = 1'b0;
    step(1);
    n_checks++; if (an !== 2'b10 || seg !== S_7) begin n_fail++; $display("[TB] FAIL scan_d0_start got an=%b seg=%b expected an=10 seg=%b", an, seg, S_7); end
    step(2);
    n_checks++; if (an !== 2'b10 || seg !== S_7) begin n_fail++; $display("[TB] FAIL scan_d0_end got an=%b seg=%b expected an=10 seg=%b", an, seg, S_7); end
    step(1);
    n_checks++; if (an !== 2'b01 || seg !== S_5) begin n_fail++; $display("[TB] FAIL scan_d1_start got an=%b seg=%b expected an=01 seg=%b", an, seg, S_5); end
    step(3);
    n_checks++; if (an !== 2'b01) begin n_fail++; $display("[TB] FAIL scan_d1_end got an=%b expected 01", an); end
    step(1);
    n_checks++; if (an !== 2'b10 || seg !== S_7) begin n_fail++; $display("[TB] FAIL scan_back_d0 got an=%b seg=%b expected an=10 seg=%b", an, seg, S_7); end
    load = 1'b1; load_val = 8'h05;
    step(1);
    load = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    exp_d1 = S_BLANK;
`else
    exp_d1 = S_0;
`endif
    step(4);
    n_checks++; if (an !== 2'b01 || seg !== exp_d1) begin n_fail++; $display("[TB] FAIL scan_lead_zero got an=%b seg=%b expected an=01 seg=%b", an, seg, exp_d1); end
    step(3);
    n_checks++; if (an !== 2'b10 || seg !== S_5) begin n_fail++; $display("[TB] FAIL scan_d0_five got an=%b seg=%b expected an=10 seg=%b", an, seg, S_5); end
  endtask

  task automatic test_async_reset();
    do_reset();
    load = 1'b1; load_val = 8'h47;
    step(1);
    load = 1'b0; en = 1'b1;
    step(2);
    n_checks++; if (count_bcd !== 8'h47) begin n_fail++; $display("[TB] FAIL areset_pre got %h expected 47", count_bcd); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (count_bcd !== 8'h00) begin n_fail++; $display("[TB] FAIL areset_count got %h expected 00", count_bcd); end
    n_checks++; if (seg !== S_BLANK || an !== 2'b11) begin n_fail++; $display("[TB] FAIL areset_display got seg=%b an=%b expected seg=%b an=11", seg, an, S_BLANK); end
    step(1);
    rst_n = 1'b1;
    step(4);
    n_checks++; if (count_bcd !== 8'h00) begin n_fail++; $display("[TB] FAIL areset_restart_early got %h expected 00", count_bcd); end
    step(1);
    n_checks++; if (count_bcd !== 8'h01) begin n_fail++; $display("[TB] FAIL areset_restart_tick got %h expected 01", count_bcd); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
    test_reset();
    test_count_up();
    test_wrap();
    test_load_priority();
    test_load_saturate();
    test_down_borrow();
    test_enable_freeze();
    test_scan();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
